// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM states, frame constants and checksum helper
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES = 2;
  localparam int CSUM_W = 8;
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] s, input logic [7:0] b);
    return s + b;
  endfunction
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, instruction-memory write port and status out
//   rx_data/rx_valid/rx_ready: byte handshake; start: re-arm pulse
//   imem_we/imem_addr/imem_wdata: memory write port; cpu_hold/done/error: status
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic start;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic cpu_hold;
  logic done;
  logic error;
  modport master(output rx_data, rx_valid, start,
                 input rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error);
  modport slave(input rx_data, rx_valid, start,
                output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error);
endinterface

// File: rtl/imem_loader_word_packer.sv
// word_packer: assembles big-endian bytes into 32-bit words
//   clk, reset (sync, active-low), clr_i: drop partial word, xfer_i/byte_i: accepted byte
//   word_valid_o: high with the 4th byte, word_o: assembled word (valid with word_valid_o)
module word_packer import imem_loader_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        xfer_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [1:0] cnt_q;
  logic [23:0] sh_q;
  assign word_valid_o = xfer_i && cnt_q == 2'(BYTES_PER_WORD - 1);
  assign word_o = {sh_q, byte_i};
  always_ff @(posedge clk)
    if (!reset || clr_i) begin
      cnt_q <= '0;
      sh_q <= '0;
    end else if (xfer_i) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q <= {sh_q[15:0], byte_i};
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader writing instruction memory and holding the CPU
//   clk, reset (sync, active-low), bus: imem_loader_if slave (stream in, write port/status out)
module imem_loader import imem_loader_pkg::*; #(parameter int ADDR_W = 8) (
  input logic clk,
  input logic reset,
  imem_loader_if.slave bus
);
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;
  state_t state_q, state_d;
  logic [7:0] len_hi_q, len_hi_d;
  logic [CSUM_W-1:0] sum_q, sum_d;
  logic [ADDR_W:0] n_q, n_d, wcnt_q, wcnt_d, wcnt_inc;
  logic we_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, word;
  logic [15:0] len16;
  logic xfer, word_valid, bad_len;
  assign bus.rx_ready = state_q inside {LEN_HI, LEN_LO, DATA, CSUM};
  assign xfer = bus.rx_valid && bus.rx_ready;
  assign len16 = {len_hi_q, bus.rx_data};
  assign bad_len = len16 == 16'd0 || {1'b0, len16} > MAX_N;
  assign wcnt_inc = wcnt_q + {{ADDR_W{1'b0}}, 1'b1};
  assign bus.imem_we = we_q;
  assign bus.imem_addr = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.done = state_q == DONE;
  assign bus.error = state_q == ERR;
  assign bus.cpu_hold = state_q != DONE;
  word_packer u_pack (
    .clk(clk),
    .reset(reset),
    .clr_i(state_q != DATA),
    .xfer_i(xfer && state_q == DATA),
    .byte_i(bus.rx_data),
    .word_valid_o(word_valid),
    .word_o(word)
  );
  always_comb begin
    state_d = state_q;
    len_hi_d = len_hi_q;
    n_d = n_q;
    wcnt_d = wcnt_q;
    sum_d = xfer ? csum_add(sum_q, bus.rx_data) : sum_q;
    addr_d = word_valid ? wcnt_q[ADDR_W-1:0] : addr_q;
    wdata_d = word_valid ? word : wdata_q;
    case (state_q)
      IDLE: state_d = LEN_HI;
      LEN_HI: if (xfer) begin
        state_d = LEN_LO;
        len_hi_d = bus.rx_data;
      end
      LEN_LO: if (xfer) begin
        state_d = bad_len ? ERR : DATA;
        n_d = len16[ADDR_W:0];
      end
      DATA: if (word_valid) begin
        wcnt_d = wcnt_inc;
        state_d = wcnt_inc == n_q ? CSUM : DATA;
      end
      CSUM: if (xfer) state_d = sum_d == '0 ? DONE : ERR;
      DONE, ERR: if (bus.start) begin
        state_d = IDLE;
        len_hi_d = '0;
        n_d = '0;
        wcnt_d = '0;
        sum_d = '0;
        addr_d = '0;
        wdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      len_hi_q <= '0;
      n_q <= '0;
      wcnt_q <= '0;
      sum_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_hi_q <= len_hi_d;
      n_q <= n_d;
      wcnt_q <= wcnt_d;
      sum_q <= sum_d;
      we_q <= word_valid;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame loads checked against a frame-level reference model
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int cyc = 0;
  logic [7:0] frame[$];
  logic [31:0] words[$];
  int wr_addr[$];
  logic [31:0] wr_data[$];
  int wr_cyc[$];
  imem_loader_if #(.ADDR_W(8)) bus();
  imem_loader #(.ADDR_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (bus.imem_we) begin
      wr_addr.push_back(int'(bus.imem_addr));
      wr_data.push_back(bus.imem_wdata);
      wr_cyc.push_back(cyc);
    end
  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    t = 0;
    if (!bus.rx_ready) stalls++;
    while (!bus.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte timeout: rx_ready got 0 want 1");
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic build_random(input int n, input logic [7:0] delta);
    logic [7:0] s;
    s = 8'h00;
    words.delete();
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = $urandom;
      words.push_back(w);
      for (int k = 3; k >= 0; k--) frame.push_back(w[8*k +: 8]);
    end
    foreach (frame[i]) s = s + frame[i];
    frame.push_back(8'h00 - s + delta);
  endtask
  task automatic check_idle(input string name);
    checks++;
    if (bus.rx_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.imem_addr !== 8'h00 ||
        bus.imem_wdata !== 32'h0 || bus.cpu_hold !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got rdy=%0b we=%0b addr=%0h wdata=%h hold=%0b done=%0b err=%0b want 0 0 0 0 1 0 0",
               name, bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_hold, bus.done, bus.error);
    end
  endtask
  task automatic check_ready(input string name, input logic exp);
    checks++;
    if (bus.rx_ready !== exp) begin
      errors++;
      $display("FAIL %s rx_ready: got %0b want %0b", name, bus.rx_ready, exp);
    end
  endtask
  task automatic rearm(input string name);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_idle({name, "_rearm"});
    @(negedge clk);
    check_ready({name, "_lenhi"}, 1'b1);
  endtask
  task automatic run_frame(input string name, input int gapmax, input bit timing);
    int n, nbytes, exp_n;
    logic [7:0] s;
    bit bad, exp_done;
    n = int'({frame[0], frame[1]});
    bad = n == 0 || n > 256;
    nbytes = bad ? 2 : frame.size();
    s = 8'h00;
    foreach (frame[i]) s = s + frame[i];
    exp_done = !bad && s == 8'h00;
    exp_n = bad ? 0 : n;
    clear_mon();
    stalls = 0;
    for (int i = 0; i < nbytes; i++) send_byte(frame[i], gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
    checks++;
    if (bus.done !== exp_done || bus.error !== !exp_done || bus.cpu_hold !== !exp_done || bus.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s result: got done=%0b err=%0b hold=%0b rdy=%0b want %0b %0b %0b 0",
               name, bus.done, bus.error, bus.cpu_hold, bus.rx_ready, exp_done, !exp_done, !exp_done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr.size() != exp_n) begin
      errors++;
      $display("FAIL %s write count: got %0d want %0d", name, wr_addr.size(), exp_n);
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL %s stalls: got %0d want 0", name, stalls);
    end
    for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] != i || wr_data[i] !== words[i]) begin
        errors++;
        $display("FAIL %s write %0d: got (%0d,%h) want (%0d,%h)", name, i, wr_addr[i], wr_data[i], i, words[i]);
      end
      if (timing && i > 0) begin
        checks++;
        if (wr_cyc[i] - wr_cyc[i-1] != 4) begin
          errors++;
          $display("FAIL %s write spacing %0d: got %0d want 4", name, i, wr_cyc[i] - wr_cyc[i-1]);
        end
      end
    end
    if (exp_n > 0) begin
      checks++;
      if (int'(bus.imem_addr) != exp_n - 1 || bus.imem_wdata !== words[exp_n-1]) begin
        errors++;
        $display("FAIL %s hold port: got (%0d,%h) want (%0d,%h)", name, bus.imem_addr, bus.imem_wdata, exp_n - 1, words[exp_n-1]);
      end
    end
  endtask
  task automatic load_fixed(input logic [7:0] csum);
    frame = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    frame.push_back(csum);
    words = '{32'h24080005, 32'h00000008};
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b1;
    check_idle("reset_release");
    @(negedge clk);
    check_ready("reset_first_ready", 1'b1);
  endtask
  task automatic test_basic();
    load_fixed(8'hC5);
    run_frame("basic", 0, 1'b0);
  endtask
  task automatic test_bad_csum();
    rearm("bad_csum");
    load_fixed(8'hC6);
    run_frame("bad_csum", 0, 1'b0);
  endtask
  task automatic test_bad_len();
    rearm("len0");
    words.delete();
    frame = '{8'h00, 8'h00, 8'h00};
    run_frame("len0", 0, 1'b0);
    rearm("len257");
    frame = '{8'h01, 8'h01};
    run_frame("len257", 0, 1'b0);
  endtask
  task automatic test_full();
    rearm("full");
    build_random(256, 8'h00);
    run_frame("full", 0, 1'b1);
  endtask
  task automatic test_gaps();
    rearm("gaps_fixed");
    load_fixed(8'hC5);
    run_frame("gaps_fixed", 5, 1'b0);
    for (int r = 0; r < 6; r++) begin
      rearm("gaps_rand");
      build_random(int'($urandom_range(1, 6)), ($urandom_range(0, 2) == 0) ? 8'(1 + $urandom_range(0, 254)) : 8'h00);
      run_frame("gaps_rand", 5, 1'b0);
    end
  endtask
  task automatic test_reset_mid();
    rearm("reset_mid");
    build_random(2, 8'h00);
    clear_mon();
    for (int i = 0; i < 5; i++) send_byte(frame[i], 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_idle("reset_mid");
    @(negedge clk);
    check_ready("reset_mid_lenhi", 1'b1);
    checks++;
    if (wr_addr.size() != 0) begin
      errors++;
      $display("FAIL reset_mid partial write: got %0d want 0", wr_addr.size());
    end
    build_random(3, 8'h00);
    run_frame("reset_mid_fresh", 2, 1'b0);
  endtask
  task automatic test_start_collision();
    rearm("collide");
    words.delete();
    frame = '{8'h00, 8'h00};
    run_frame("collide_err", 0, 1'b0);
    bus.start = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b1;
    check_ready("collide_err_ready", 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.rx_valid = 1'b0;
    check_idle("collide_idle");
    @(negedge clk);
    check_ready("collide_lenhi", 1'b1);
    build_random(2, 8'h00);
    run_frame("collide_fresh", 1, 1'b0);
  endtask
  initial begin
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_csum();
    test_bad_len();
    test_full();
    test_gaps();
    test_reset_mid();
    test_start_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle MIPS CPU. Receives a framed byte stream (length, big-endian 32-bit instruction words, checksum) over a valid/ready byte interface and writes each assembled word into instruction memory through its write port, the opposite side of the fetch stage's read-only access. The CPU is held via `cpu_hold`, wired to the CPU's reset and `PCWrite` gating, until a load completes with a good checksum.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width. Depth is `2**ADDR_W` words.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte. A byte transfers when `rx_valid && rx_ready` at a rising edge.
- `start`  in  1  re-arm pulse. Honoured only in DONE or ERR.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word index being written.
- `imem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  1 = CPU held in reset with PC frozen.
- `done`  out  1  load completed, checksum good.
- `error`  out  1  load rejected.

## Operation
- Frame, in order: LEN_HI, LEN_LO (word count N, 16-bit big-endian), then N×4 payload bytes (each word MSB first), then CSUM.
- Checksum rule: the 8-bit sum of all frame bytes, including the length bytes and CSUM, must be 0 mod 256.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- IDLE always moves to LEN_HI on the next cycle.
- LEN_HI moves to LEN_LO on a byte transfer.
- At the LEN_LO transfer:
  - If N == 0 or N > 2**ADDR_W, go to ERR. No further bytes are consumed.
  - Otherwise go to DATA.
- DATA:
  - A 2-bit byte counter shifts bytes into a 32-bit assembly register.
  - On the 4th byte, the word is registered and written (see Timing), and the word counter increments.
  - After word N-1 is accepted, go to CSUM.
- CSUM: on transfer, if running sum + byte == 0 mod 256 go to DONE, else go to ERR.
- DONE and ERR are sticky. `start` in either state goes to IDLE and clears the counters and running sum. `start` in any other state is ignored.
- `rx_ready` = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in IDLE, DONE and ERR.
- `cpu_hold` = 0 only in DONE. `done` = 1 only in DONE; `error` = 1 only in ERR.
- Words written before an error stay in memory; the loader never erases. A CPU release requires a full good frame.
- The running sum is 8-bit and wraps. The word counter is ADDR_W+1 bits so N = 2**ADDR_W is legal.

## Timing
- Reset values, and the values in IDLE: state IDLE, `rx_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_hold` 1, `done` 0, `error` 0.
- The first `rx_ready` is one cycle after reset deasserts.
- `imem_we`, `imem_addr` and `imem_wdata` are registered. The write strobe is high for exactly the cycle after the 4th byte of a word transfers. Address and data hold their values until the next write.
- `rx_ready` stays high during the write cycle, so back-to-back bytes are sustained at 1 byte/cycle with no bubbles.
- The `done`/`error` transition is registered: the flag rises the cycle after the CSUM or LEN_LO transfer.
- `cpu_hold` falls in the same cycle `done` rises.
- A `rx_valid` stall of any length between bytes is legal and does not change counters.
- `reset` mid-frame: the cycle after reset returns to IDLE with all counters cleared and `cpu_hold` = 1. A partial word is discarded and not written.
- `start` and `rx_valid` in the same DONE/ERR cycle: `start` wins and the byte is not accepted (`rx_ready` = 0).

## Structure
- Package `imem_loader_pkg`:
  - state enum;
  - constants `BYTES_PER_WORD` = 4 and `HDR_BYTES` = 2;
  - checksum width 8.
- One sub-module, `word_packer`: 2-bit byte counter, shift register and a `word_valid` pulse on the 4th byte. It is cleared by `reset` and by the FSM leaving DATA.
- The top module holds the FSM, word counter, running sum and the registered write port.

## Test plan
- Load N=2: 00 02, 24 08 00 05, 00 00 00 08, CSUM 0xC5 → writes (0, 0x24080005) then (1, 0x00000008); `done` = 1 and `cpu_hold` = 0 one cycle after CSUM.
- Same frame with CSUM 0xC6 → both words are written, `error` = 1, `cpu_hold` stays 1, `rx_ready` = 0.
- Length 00 00, and separately length 01 01 with ADDR_W=8 → ERR right after LEN_LO; no `imem_we` pulses.
- N = 256 with continuous `rx_valid` → 256 writes at addresses 0..255, one write every 4 cycles, no `rx_ready` drop before CSUM.
- Random `rx_valid` gaps of 0–5 cycles on the N=2 frame → identical writes and result; `reset` pulse after 3 payload bytes → no write, state IDLE, then a fresh frame loads correctly.
- After ERR, pulse `start` together with `rx_valid` → byte not accepted; next cycle IDLE, then LEN_HI with `rx_ready` = 1.
